// File: rtl/e_alloc.sv
// Circular first-free slot allocator with grouped priority search, occupancy
// tracking, sticky error flag and an optional registered grant stage.
module e_alloc #(
   parameter int unsigned W       = 32,
   parameter int unsigned RADIX_N = 4,
   parameter int unsigned REG_OUT = 0
) (
   input  logic                  clk,
   input  logic                  arst_n,
   output logic                  alloc_vld_o,
   input  logic                  alloc_rdy_i,
   output logic [$clog2(W)-1:0]  alloc_id_o,
   input  logic                  free_vld_i,
   input  logic [$clog2(W)-1:0]  free_id_i,
   output logic [W-1:0]          occ_o,
   output logic [$clog2(W):0]    count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  err_o
);

   localparam int unsigned LW = $clog2(W);
   localparam int unsigned NG = (2 * W + RADIX_N - 1) / RADIX_N;
   localparam int unsigned PW = NG * RADIX_N;

   logic [W-1:0]  occ, occ_nxt;
   logic [LW-1:0] ptr, ptr_nxt;
   logic [LW:0]   cnt, cnt_nxt;
   logic          err;
   logic          accept, free_ok, free_bad;

   // Lower copy masked below p, upper copy unmasked: the lowest set bit of the
   // doubled word is the first free slot at or after p, wrapping around.
   function automatic logic [LW:0] search(input logic [W-1:0] o, input logic [LW-1:0] p);
      logic [PW-1:0]      word;
      logic [NG-1:0]      any;
      logic [RADIX_N-1:0] grp;
      int unsigned        sel, bsel, pos;
      word = '0;
      for (int unsigned i = 0; i < W; i++) begin
         word[i]     = ~o[i] & (i >= 32'(p));
         word[i + W] = ~o[i];
      end
      for (int unsigned g = 0; g < NG; g++) begin
         any[g] = |word[g * RADIX_N +: RADIX_N];
      end
      sel = 0;
      for (int unsigned g = NG; g > 0; g--) begin
         if (any[g - 1]) sel = g - 1;
      end
      grp  = word[sel * RADIX_N +: RADIX_N];
      bsel = 0;
      for (int unsigned b = RADIX_N; b > 0; b--) begin
         if (grp[b - 1]) bsel = b - 1;
      end
      pos = sel * RADIX_N + bsel;
      return {|any, LW'(pos % W)};
   endfunction

   always_comb begin
      accept   = alloc_vld_o & alloc_rdy_i;
      free_ok  = free_vld_i & occ[free_id_i];
      free_bad = free_vld_i & ~occ[free_id_i];
      occ_nxt  = occ;
      if (free_ok) occ_nxt[free_id_i] = 1'b0;
      if (accept)  occ_nxt[alloc_id_o] = 1'b1;
      ptr_nxt = accept ? alloc_id_o + LW'(1) : ptr;
      cnt_nxt = cnt;
      if (accept && !free_ok)      cnt_nxt = cnt + (LW + 1)'(1);
      else if (free_ok && !accept) cnt_nxt = cnt - (LW + 1)'(1);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         occ <= '0;
         ptr <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         occ <= occ_nxt;
         ptr <= ptr_nxt;
         cnt <= cnt_nxt;
         err <= err | free_bad;
      end
   end

   if (REG_OUT != 0) begin : g_reg
      logic [LW:0] offer_q;
      // Loading from next state keeps the registered offer coherent with occ.
      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) offer_q <= '0;
         else         offer_q <= search(occ_nxt, ptr_nxt);
      end
      assign alloc_vld_o = offer_q[LW];
      assign alloc_id_o  = offer_q[LW-1:0];
   end else begin : g_comb
      logic [LW:0] cur;
      assign cur         = search(occ, ptr);
      assign alloc_vld_o = arst_n & cur[LW];
      assign alloc_id_o  = cur[LW-1:0];
   end

   assign occ_o   = occ;
   assign count_o = cnt;
   assign full_o  = (cnt == (LW + 1)'(W));
   assign empty_o = (cnt == '0);
   assign err_o   = err;

endmodule

// File: tb/tb_e_alloc.sv
// Bench for e_alloc: directed vector table, corner sequences and random
// traffic against a slot-list reference model, on a combinational and a registered instance.
module tb_e_alloc;

   logic        clk = 1'b0;
   logic        arst_n, rdy, fv;
   logic [3:0]  fid;
   logic        v0, v1, full0, full1, empty0, empty1, err0, err1;
   logic [3:0]  id0, id1;
   logic [15:0] occ0, occ1;
   logic [4:0]  cnt0, cnt1;

   e_alloc #(.W(16), .RADIX_N(4), .REG_OUT(0)) u_comb (
      .clk(clk), .arst_n(arst_n), .alloc_vld_o(v0), .alloc_rdy_i(rdy), .alloc_id_o(id0),
      .free_vld_i(fv), .free_id_i(fid), .occ_o(occ0), .count_o(cnt0),
      .full_o(full0), .empty_o(empty0), .err_o(err0));

   e_alloc #(.W(16), .RADIX_N(5), .REG_OUT(1)) u_reg (
      .clk(clk), .arst_n(arst_n), .alloc_vld_o(v1), .alloc_rdy_i(rdy), .alloc_id_o(id1),
      .free_vld_i(fv), .free_id_i(fid), .occ_o(occ1), .count_o(cnt1),
      .full_o(full1), .empty_o(empty1), .err_o(err1));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: per-slot busy bits, search pointer, count, sticky error
   logic [15:0] m_occ;
   int          m_ptr, m_cnt;
   bit          m_err, m_rst, m_fresh;

   typedef struct {
      bit rdy; bit fv; int fid;
      bit vld; int id; int cnt; bit err;
   } vec_t;
   vec_t tbl[32];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_cand();
      for (int k = 0; k < 16; k++) begin
         if (!m_occ[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
      end
      return 0;
   endfunction

   task automatic check_all();
      int c;
      bit ev0, ev1;
      c   = m_cand();
      ev0 = (m_occ != 16'hFFFF) && !m_rst;
      ev1 = ev0 && !m_fresh;
      chk("comb_vld", int'(v0), int'(ev0));
      if (ev0) chk("comb_id", int'(id0), c);
      chk("comb_occ", int'(occ0), int'(m_occ));
      chk("comb_cnt", int'(cnt0), m_cnt);
      chk("comb_full", int'(full0), int'(m_cnt == 16));
      chk("comb_empty", int'(empty0), int'(m_cnt == 0));
      chk("comb_err", int'(err0), int'(m_err));
      chk("reg_vld", int'(v1), int'(ev1));
      if (ev1) chk("reg_id", int'(id1), c);
      chk("reg_occ", int'(occ1), int'(m_occ));
      chk("reg_cnt", int'(cnt1), m_cnt);
      chk("reg_full", int'(full1), int'(m_cnt == 16));
      chk("reg_empty", int'(empty1), int'(m_cnt == 0));
      chk("reg_err", int'(err1), int'(m_err));
   endtask

   task automatic step(input bit r, input bit f, input int id);
      bit acc;
      int c;
      rdy = r; fv = f; fid = 4'(id);
      #1;
      check_all();
      c   = m_cand();
      acc = r && (m_occ != 16'hFFFF);
      if (f) begin
         if (m_occ[id]) begin m_occ[id] = 1'b0; m_cnt--; end
         else m_err = 1'b1;
      end
      if (acc) begin
         m_occ[c] = 1'b1;
         m_cnt++;
         m_ptr = (c + 1) % 16;
      end
      @(posedge clk);
      #1;
      m_fresh = 1'b0;
   endtask

   task automatic do_reset();
      rdy = 1'b0; fv = 1'b0; fid = '0;
      arst_n = 1'b0;
      m_occ = '0; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_rst = 1'b1; m_fresh = 1'b1;
      #1;
      check_all();
      @(posedge clk); #1;
      @(posedge clk); #1;
      arst_n = 1'b1;
      m_rst  = 1'b0;
      step(0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) tbl[i] = '{1, 0, 0, 1, i, i, 0};
      tbl[16] = '{0, 1, 5,  0, 0, 16, 0};
      tbl[17] = '{1, 0, 0,  1, 5, 15, 0};
      tbl[18] = '{0, 1, 2,  0, 0, 16, 0};
      tbl[19] = '{0, 1, 9,  1, 2, 15, 0};
      tbl[20] = '{1, 0, 0,  1, 9, 14, 0};
      tbl[21] = '{1, 0, 0,  1, 2, 15, 0};
      tbl[22] = '{0, 1, 4,  0, 0, 16, 0};
      tbl[23] = '{1, 1, 7,  1, 4, 15, 0};
      tbl[24] = '{0, 0, 0,  1, 7, 15, 0};
      tbl[25] = '{0, 1, 7,  1, 7, 15, 0};
      tbl[26] = '{1, 0, 0,  1, 7, 15, 1};
      tbl[27] = '{0, 1, 0,  0, 0, 16, 1};
      tbl[28] = '{1, 0, 0,  1, 0, 15, 1};
      tbl[29] = '{0, 1, 3,  0, 0, 16, 1};
      tbl[30] = '{1, 1, 3,  1, 3, 15, 1};
      tbl[31] = '{0, 0, 0,  0, 0, 16, 1};

      rdy = 1'b0; fv = 1'b0; fid = '0;
      arst_n = 1'b1;
      #1;
      do_reset();

      // directed vectors: expectations are the pre-edge outputs of the combinational instance
      for (int i = 0; i < 32; i++) begin
         rdy = tbl[i].rdy; fv = tbl[i].fv; fid = 4'(tbl[i].fid);
         #1;
         chk("tbl_vld", int'(v0), int'(tbl[i].vld));
         if (tbl[i].vld) chk("tbl_id", int'(id0), tbl[i].id);
         chk("tbl_cnt", int'(cnt0), tbl[i].cnt);
         chk("tbl_err", int'(err0), int'(tbl[i].err));
         step(tbl[i].rdy, tbl[i].fv, tbl[i].fid);
      end

      // empty occupancy with pointer at 15 offers slot 15
      step(0, 1, 14);
      step(1, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, i);
      rdy = 1'b0; fv = 1'b0;
      #1;
      chk("wrap15_comb", int'(id0), 15);
      chk("wrap15_reg", int'(id1), 15);
      step(0, 0, 0);

      // free of the slot being accepted: error flagged, allocation kept
      do_reset();
      step(1, 1, 0);
      chk("same_err", int'(err0), 1);
      chk("same_occ0", int'(occ0[0]), 1);
      chk("same_cnt", int'(cnt0), 1);
      for (int i = 0; i < 15; i++) step(1, 0, 0);
      chk("fill_full", int'(full1), 1);

      // registered stage: freed slot offered after the sampling edge, then reset mid-offer
      step(0, 1, 10);
      chk("reg_free_vld", int'(v1), 1);
      chk("reg_free_id", int'(id1), 10);
      #2;
      arst_n = 1'b0;
      #1;
      chk("rst_async_vld_reg", int'(v1), 0);
      chk("rst_async_vld_comb", int'(v0), 0);
      chk("rst_async_occ", int'(occ1), 0);
      do_reset();

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
